// File: rtl/ph_pkg.sv
// ph_pkg: shared types and constants for the ph shift-register link
package ph_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ph_rx_state_t;
    localparam int PH_W = 4;
endpackage

// File: rtl/ph_rx.sv
// ph_rx: serial-to-parallel receiver, W bits MSB-first framed by load, qualified by sft
//   clk, clr      clock, synchronous active-high reset
//   load          frame start strobe (restart with err when mid-frame)
//   sft, sin      bit strobe and serial data
//   qph, vld      last completed word, one-cycle update pulse
//   busy, err     frame in progress, sticky framing error
module ph_rx
    import ph_pkg::*;
#(
    parameter int W = PH_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         sft,
    input  logic         sin,
    output logic [W-1:0] qph,
    output logic         vld,
    output logic         busy,
    output logic         err
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    ph_rx_state_t  state_q;
    logic [W-1:0]  sreg_q, qph_q, sreg_d;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    assign sreg_d = {sreg_q[W-2:0], sin};
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            qph_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (load) begin
                    state_q <= SHIFT;
                    sreg_q  <= '0;
                    cnt_q   <= '0;
                end
                SHIFT: if (load) begin
                    // restart wins over a coincident strobe; that bit is dropped
                    sreg_q <= '0;
                    cnt_q  <= '0;
                    err_q  <= 1'b1;
                end else if (sft) begin
                    sreg_q <= sreg_d;
                    if (cnt_q == LAST) begin
                        qph_q   <= sreg_d;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= load ? SHIFT : IDLE;
                    if (load) begin
                        sreg_q <= '0;
                        cnt_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign qph  = qph_q;
    assign vld  = state_q == DONE;
    assign busy = state_q == SHIFT;
    assign err  = err_q;
endmodule
